// File: rtl/la_eth_uploader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : la_eth_uploader_if                                              |
// | Brief    : FIFO read side, UDP transmit handshake and status of the        |
// |            logic-analyser uploader.                                        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface la_eth_uploader_if #(
    parameter int WORD_WIDTH = 256,
    parameter int CNT_WIDTH  = 10,
    parameter int LEN_WIDTH  = 16
);
    logic                  arm;
    logic                  capture_done;
    logic [WORD_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  fifo_rd_cnt;
    logic                  fifo_rd_en;
    logic                  udp_tx_req;
    logic [LEN_WIDTH-1:0]  udp_tx_len;
    logic                  udp_tx_ack;
    logic                  udp_tx_data_req;
    logic [7:0]            udp_tx_data;
    logic                  udp_tx_done;
    logic                  read_done;
    logic [15:0]           pkt_seq;

    modport master (
        input  arm, capture_done, fifo_dout, fifo_empty, fifo_rd_cnt,
               udp_tx_ack, udp_tx_data_req, udp_tx_done,
        output fifo_rd_en, udp_tx_req, udp_tx_len, udp_tx_data, read_done, pkt_seq
    );

    modport slave (
        output arm, capture_done, fifo_dout, fifo_empty, fifo_rd_cnt,
               udp_tx_ack, udp_tx_data_req, udp_tx_done,
        input  fifo_rd_en, udp_tx_req, udp_tx_len, udp_tx_data, read_done, pkt_seq
    );
endinterface
`default_nettype wire

// File: rtl/la_eth_uploader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : la_eth_uploader                                                 |
// | Brief    : Drains the capture FIFO into UDP packets, one byte per engine   |
// |            data request. Optional 4-byte header: LA_UPLOAD_HEADER_EN.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module la_eth_uploader #(
    parameter int WORD_WIDTH = 256,
    parameter int CNT_WIDTH  = 10,
    parameter int PKT_WORDS  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    la_eth_uploader_if.master bus
);

    localparam int c_BYTES = WORD_WIDTH / 8;
    localparam int c_IDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(c_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] c_PKT_WORDS = CNT_WIDTH'(PKT_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_REQ  = 3'd2,
        S_HDR  = 3'd3,
        S_SEND = 3'd4,
        S_GAP  = 3'd5
    } state_t;

`ifdef LA_UPLOAD_HEADER_EN
    localparam logic [LEN_WIDTH-1:0] c_HDR_LEN   = LEN_WIDTH'(4);
    localparam logic [c_IDX_W-1:0]   c_HDR_LAST  = c_IDX_W'(3);
    localparam state_t               c_FIRST_DAT = S_HDR;
    logic [CNT_WIDTH-1:0] r_n_words;
`else
    localparam logic [LEN_WIDTH-1:0] c_HDR_LEN   = '0;
    localparam state_t               c_FIRST_DAT = S_SEND;
`endif

    state_t                r_state, w_next;
    logic [WORD_WIDTH-1:0] r_word_buf;
    logic [c_IDX_W-1:0]    r_byte_idx, w_idx_next;
    logic [CNT_WIDTH-1:0]  r_words_left, w_n;
    logic [LEN_WIDTH-1:0]  r_tx_len, w_len;
    logic [7:0]            r_tx_data, w_emit_byte;
    logic [15:0]           r_pkt_seq;
    logic                  r_tx_req, r_read_done, r_loaded, r_acked, r_done_seen;
    logic                  w_pop, w_emit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_emit      = 1'b0;
        w_n         = '0;
        w_idx_next  = r_byte_idx + 1'b1;
        w_emit_byte = r_word_buf[{r_byte_idx, 3'b000} +: 8];
        case (r_state)
            S_IDLE: if (bus.arm) w_next = S_WAIT;
            S_WAIT: begin
                if (bus.fifo_rd_cnt >= c_PKT_WORDS) begin
                    w_n    = c_PKT_WORDS;
                    w_next = S_REQ;
                end else if (bus.capture_done && bus.fifo_rd_cnt != '0) begin
                    w_n    = bus.fifo_rd_cnt;
                    w_next = S_REQ;
                end else if (bus.capture_done && bus.fifo_empty) begin
                    w_next = S_IDLE;
                end
            end
            // First word is popped exactly once, whether or not ack has come yet
            S_REQ: begin
                w_pop = !r_loaded && !bus.fifo_empty;
                if ((r_acked || bus.udp_tx_ack) && (r_loaded || w_pop))
                    w_next = c_FIRST_DAT;
            end
`ifdef LA_UPLOAD_HEADER_EN
            S_HDR: begin
                case (r_byte_idx[1:0])
                    2'd0:    w_emit_byte = r_pkt_seq[15:8];
                    2'd1:    w_emit_byte = r_pkt_seq[7:0];
                    2'd2:    w_emit_byte = 8'(r_n_words);
                    default: w_emit_byte = 8'hA5;
                endcase
                if (bus.udp_tx_data_req) begin
                    w_emit = 1'b1;
                    if (r_byte_idx == c_HDR_LAST) begin
                        w_idx_next = '0;
                        w_next     = S_SEND;
                    end
                end
            end
`endif
            // An empty FIFO at a word boundary stalls the byte rather than emit stale data
            S_SEND: begin
                if (bus.udp_tx_data_req) begin
                    if (r_byte_idx == c_LAST_IDX) begin
                        w_idx_next = '0;
                        if (r_words_left != '0) begin
                            if (!bus.fifo_empty) begin
                                w_pop  = 1'b1;
                                w_emit = 1'b1;
                            end
                        end else begin
                            w_emit = 1'b1;
                            w_next = S_GAP;
                        end
                    end else begin
                        w_emit = 1'b1;
                    end
                end
            end
            S_GAP: if (bus.udp_tx_done || r_done_seen) w_next = S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_len = LEN_WIDTH'(w_n) * LEN_WIDTH'(c_BYTES) + c_HDR_LEN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_buf   <= '0;
            r_byte_idx   <= '0;
            r_words_left <= '0;
            r_tx_len     <= '0;
            r_tx_data    <= '0;
            r_pkt_seq    <= '0;
            r_tx_req     <= 1'b0;
            r_read_done  <= 1'b1;
            r_loaded     <= 1'b0;
            r_acked      <= 1'b0;
            r_done_seen  <= 1'b0;
`ifdef LA_UPLOAD_HEADER_EN
            r_n_words    <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && bus.arm) begin
                r_read_done <= 1'b0;
                r_pkt_seq   <= '0;
            end
            if (r_state == S_WAIT && w_next == S_IDLE)
                r_read_done <= 1'b1;
            if (r_state == S_WAIT && w_next == S_REQ) begin
                r_tx_req     <= 1'b1;
                r_tx_len     <= w_len;
                r_words_left <= w_n - 1'b1;
                r_byte_idx   <= '0;
                r_loaded     <= 1'b0;
                r_acked      <= 1'b0;
                r_done_seen  <= 1'b0;
`ifdef LA_UPLOAD_HEADER_EN
                r_n_words    <= w_n;
`endif
            end
            if (r_state == S_REQ && bus.udp_tx_ack) begin
                r_tx_req <= 1'b0;
                r_acked  <= 1'b1;
            end
            if (w_pop) begin
                r_word_buf <= bus.fifo_dout;
                if (r_state == S_REQ) r_loaded     <= 1'b1;
                else                  r_words_left <= r_words_left - 1'b1;
            end
            if (w_emit) begin
                r_tx_data  <= w_emit_byte;
                r_byte_idx <= w_idx_next;
            end
            // Engine may report completion before the last byte leaves this block
            if (bus.udp_tx_done && (r_state == S_REQ || r_state == S_HDR || r_state == S_SEND))
                r_done_seen <= 1'b1;
            if (r_state == S_GAP && w_next == S_WAIT) begin
                r_pkt_seq   <= r_pkt_seq + 16'd1;
                r_done_seen <= 1'b0;
            end
        end
    end

    assign bus.fifo_rd_en  = w_pop;
    assign bus.udp_tx_req  = r_tx_req;
    assign bus.udp_tx_len  = r_tx_len;
    assign bus.udp_tx_data = r_tx_data;
    assign bus.read_done   = r_read_done;
    assign bus.pkt_seq     = r_pkt_seq;

endmodule
`default_nettype wire

// File: tb/tb_la_eth_uploader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_la_eth_uploader                                              |
// | Brief    : Directed bench: FIFO model plus UDP engine driver around        |
// |            la_eth_uploader. Header checks follow LA_UPLOAD_HEADER_EN.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_la_eth_uploader;

`ifdef LA_UPLOAD_HEADER_EN
    localparam int H = 4;
`else
    localparam int H = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    la_eth_uploader_if #(.WORD_WIDTH(256), .CNT_WIDTH(10), .LEN_WIDTH(16)) bus ();

    la_eth_uploader #(
        .WORD_WIDTH(256),
        .CNT_WIDTH (10),
        .PKT_WORDS (32),
        .LEN_WIDTH (16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Show-ahead FIFO model
    logic [255:0] mem [0:255];
    logic [7:0]   wr_ptr = 8'd0;
    logic [7:0]   rd_ptr = 8'd0;
    logic [7:0]   w_cnt;
    bit           fifo_flush = 1'b0;
    int           pop_cnt = 0;
    int           bad_pop = 0;

    assign w_cnt           = wr_ptr - rd_ptr;
    assign bus.fifo_dout   = mem[rd_ptr];
    assign bus.fifo_empty  = (w_cnt == 8'd0);
    assign bus.fifo_rd_cnt = {2'b00, w_cnt};

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en === 1'b1) begin
            if (w_cnt == 8'd0) begin
                bad_pop <= bad_pop + 1;
            end else begin
                rd_ptr  <= rd_ptr + 8'd1;
                pop_cnt <= pop_cnt + 1;
            end
        end
    end

    logic [7:0] rx   [0:2047];
    bit         rden [0:2047];

    function automatic logic [7:0] exp_byte(input int k, input int lane, input bit alt);
        logic [31:0] kk, ll;
        kk = k;
        ll = lane;
        if (alt) return {kk[2:0], ll[4:0]};
        else     return {kk[4:0], ll[2:0]};
    endfunction

    task automatic preload(input int n, input int k0, input bit alt);
        logic [255:0] w;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 32; j++) w[j*8 +: 8] = exp_byte(k0 + i, j, alt);
            mem[wr_ptr] = w;
            wr_ptr = wr_ptr + 8'd1;
        end
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        @(posedge clk); #1;
        bus.arm = 1'b0;
    endtask

    // UDP engine: grant after ack_delay, pull nbytes back-to-back, then extra requests, then done
    task automatic engine_packet(input int ack_delay, input int nbytes, input int extra,
                                 output bit got_req, output int len, output int hold_bad,
                                 output int pops_at_send);
        got_req = 1'b0; len = 0; hold_bad = 0; pops_at_send = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (bus.udp_tx_req === 1'b1) begin
                got_req = 1'b1;
                break;
            end
        end
        if (!got_req) return;
        len = int'(bus.udp_tx_len);
        for (int d = 0; d < ack_delay; d++) begin
            @(posedge clk); #1;
            if (bus.udp_tx_req !== 1'b1 || int'(bus.udp_tx_len) != len) hold_bad++;
        end
        bus.udp_tx_ack = 1'b1;
        @(posedge clk); #1;
        bus.udp_tx_ack = 1'b0;
        pops_at_send = pop_cnt;
        for (int i = 0; i < nbytes + extra; i++) begin
            bus.udp_tx_data_req = 1'b1;
            #1;
            rden[i] = (bus.fifo_rd_en === 1'b1);
            @(posedge clk); #1;
            rx[i] = bus.udp_tx_data;
        end
        bus.udp_tx_data_req = 1'b0;
        bus.udp_tx_done = 1'b1;
        @(posedge clk); #1;
        bus.udp_tx_done = 1'b0;
    endtask

    task automatic wait_read_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int t = 0; t < limit && !seen; t++) begin
            @(posedge clk); #1;
            if (bus.read_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.read_done !== 1'b1) begin miscompares++; $display("FAIL reset_read_done: got %b want 1", bus.read_done); end
        vectors++; if (bus.udp_tx_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", bus.udp_tx_req); end
        vectors++; if (bus.udp_tx_len !== 16'd0) begin miscompares++; $display("FAIL reset_len: got %0d want 0", bus.udp_tx_len); end
        vectors++; if (bus.udp_tx_data !== 8'd0) begin miscompares++; $display("FAIL reset_data: got %02h want 00", bus.udp_tx_data); end
        vectors++; if (bus.pkt_seq !== 16'd0) begin miscompares++; $display("FAIL reset_pkt_seq: got %0d want 0", bus.pkt_seq); end
        vectors++; if (bus.fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (bus.read_done !== 1'b1) begin miscompares++; $display("FAIL idle_read_done: got %b want 1", bus.read_done); end
    endtask

    task automatic test_two_full();
        bit got, seen; int len, hb, ps, base, errs, fi; logic [7:0] fg, fw;
        base = pop_cnt;
        preload(64, 0, 1'b1);
        bus.capture_done = 1'b1;
        do_arm();
        vectors++; if (bus.read_done !== 1'b0) begin miscompares++; $display("FAIL full_arm_read_done: got %b want 0", bus.read_done); end
        for (int p = 0; p < 2; p++) begin
            engine_packet(0, H + 1024, 0, got, len, hb, ps);
            vectors++; if (!got) begin miscompares++; $display("FAIL full_req%0d: got none want udp_tx_req", p); end
            vectors++; if (len != 1024 + H) begin miscompares++; $display("FAIL full_len%0d: got %0d want %0d", p, len, 1024 + H); end
`ifdef LA_UPLOAD_HEADER_EN
            vectors++; if ({rx[0], rx[1], rx[2], rx[3]} !== (p == 0 ? 32'h000020A5 : 32'h000120A5)) begin
                miscompares++; $display("FAIL full_hdr%0d: got %02h %02h %02h %02h", p, rx[0], rx[1], rx[2], rx[3]); end
`endif
            errs = 0; fi = 0; fg = 0; fw = 0;
            for (int i = 0; i < 1024; i++)
                if (rx[H+i] !== exp_byte(p*32 + i/32, i%32, 1'b1)) begin
                    if (errs == 0) begin fi = i; fg = rx[H+i]; fw = exp_byte(p*32 + i/32, i%32, 1'b1); end
                    errs++;
                end
            vectors++; if (errs != 0) begin miscompares++; $display("FAIL full_payload%0d: %0d bad, first byte %0d got %02h want %02h", p, errs, fi, fg, fw); end
        end
        vectors++; if (bus.read_done !== 1'b0) begin miscompares++; $display("FAIL full_early_read_done: got %b want 0", bus.read_done); end
        wait_read_done(4, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL full_read_done: got 0 want 1 within 4 cycles"); end
        vectors++; if (pop_cnt - base != 64) begin miscompares++; $display("FAIL full_pops: got %0d want 64", pop_cnt - base); end
        vectors++; if (bus.pkt_seq !== 16'd2) begin miscompares++; $display("FAIL full_pkt_seq: got %0d want 2", bus.pkt_seq); end
        vectors++; if (bad_pop != 0) begin miscompares++; $display("FAIL full_empty_pop: got %0d want 0", bad_pop); end
    endtask

    task automatic test_short_final();
        bit got, seen; int len, hb, ps, base, errs, fi; logic [7:0] fg, fw;
        base = pop_cnt;
        preload(40, 0, 1'b1);
        do_arm();
        engine_packet(0, H + 1024, 0, got, len, hb, ps);
        vectors++; if (len != 1024 + H) begin miscompares++; $display("FAIL short_len0: got %0d want %0d", len, 1024 + H); end
        engine_packet(0, H + 256, 0, got, len, hb, ps);
        vectors++; if (len != 256 + H) begin miscompares++; $display("FAIL short_len1: got %0d want %0d", len, 256 + H); end
`ifdef LA_UPLOAD_HEADER_EN
        vectors++; if ({rx[0], rx[1], rx[2], rx[3]} !== 32'h000108A5) begin
            miscompares++; $display("FAIL short_hdr1: got %02h %02h %02h %02h want 00 01 08 a5", rx[0], rx[1], rx[2], rx[3]); end
`endif
        errs = 0; fi = 0; fg = 0; fw = 0;
        for (int i = 0; i < 256; i++)
            if (rx[H+i] !== exp_byte(32 + i/32, i%32, 1'b1)) begin
                if (errs == 0) begin fi = i; fg = rx[H+i]; fw = exp_byte(32 + i/32, i%32, 1'b1); end
                errs++;
            end
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL short_payload1: %0d bad, first byte %0d got %02h want %02h", errs, fi, fg, fw); end
        wait_read_done(4, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL short_read_done: got 0 want 1"); end
        vectors++; if (pop_cnt - base != 40) begin miscompares++; $display("FAIL short_pops: got %0d want 40", pop_cnt - base); end
    endtask

    task automatic test_stream();
        bit got, seen; int len, hb, ps, base, errs, npop; logic [7:0] last;
        base = pop_cnt;
        preload(2, 0, 1'b0);
        do_arm();
        engine_packet(0, H + 64, 2, got, len, hb, ps);
        vectors++; if (len != 64 + H) begin miscompares++; $display("FAIL stream_len: got %0d want %0d", len, 64 + H); end
        errs = 0;
        for (int i = 0; i < 64; i++) if (rx[H+i] !== exp_byte(i/32, i%32, 1'b0)) errs++;
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL stream_order: got %0d bad bytes want 0", errs); end
        vectors++; if (!rden[H+31]) begin miscompares++; $display("FAIL stream_boundary_pop: got 0 want 1 on byte 31"); end
        npop = 0;
        for (int i = 0; i < H + 66; i++) if (rden[i]) npop++;
        vectors++; if (npop != 1) begin miscompares++; $display("FAIL stream_send_pops: got %0d want 1", npop); end
        last = exp_byte(1, 31, 1'b0);
        vectors++; if (rx[H+64] !== last || rx[H+65] !== last) begin
            miscompares++; $display("FAIL stream_extra_req: got %02h %02h want %02h", rx[H+64], rx[H+65], last); end
        vectors++; if (pop_cnt - base != 2) begin miscompares++; $display("FAIL stream_pops: got %0d want 2", pop_cnt - base); end
        wait_read_done(4, seen);
        vectors++; if (bus.pkt_seq !== 16'd1) begin miscompares++; $display("FAIL stream_pkt_seq: got %0d want 1", bus.pkt_seq); end
    endtask

    task automatic test_ack_delay();
        bit got, seen; int len, hb, ps, base, errs;
        base = pop_cnt;
        preload(32, 5, 1'b1);
        do_arm();
        engine_packet(10, H + 1024, 0, got, len, hb, ps);
        vectors++; if (hb != 0) begin miscompares++; $display("FAIL ackdly_hold: got %0d unstable cycles want 0", hb); end
        vectors++; if (ps - base != 1) begin miscompares++; $display("FAIL ackdly_pops_before_send: got %0d want 1", ps - base); end
        vectors++; if (len != 1024 + H) begin miscompares++; $display("FAIL ackdly_len: got %0d want %0d", len, 1024 + H); end
        errs = 0;
        for (int i = 0; i < 1024; i++) if (rx[H+i] !== exp_byte(5 + i/32, i%32, 1'b1)) errs++;
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL ackdly_payload: got %0d bad bytes want 0", errs); end
        wait_read_done(4, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL ackdly_read_done: got 0 want 1"); end
    endtask

    task automatic test_empty_done();
        bit seen; int reqs;
        do_arm();
        vectors++; if (bus.read_done !== 1'b0) begin miscompares++; $display("FAIL empty_arm_read_done: got %b want 0", bus.read_done); end
        wait_read_done(2, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL empty_read_done: got 0 want 1 within 2 cycles"); end
        reqs = 0;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            if (bus.udp_tx_req !== 1'b0) reqs++;
        end
        vectors++; if (reqs != 0) begin miscompares++; $display("FAIL empty_req: got %0d req cycles want 0", reqs); end
    endtask

    task automatic test_rst_mid();
        bit got, seen; int len, hb, ps, base, errs;
        preload(64, 0, 1'b1);
        do_arm();
        engine_packet(0, H + 1024, 0, got, len, hb, ps);
        vectors++; if (bus.pkt_seq !== 16'd1) begin miscompares++; $display("FAIL rst_pre_pkt_seq: got %0d want 1", bus.pkt_seq); end
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(posedge clk); #1;
            if (bus.udp_tx_req === 1'b1) got = 1'b1;
        end
        bus.udp_tx_ack = 1'b1;
        @(posedge clk); #1;
        bus.udp_tx_ack = 1'b0;
        bus.udp_tx_data_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.udp_tx_data_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.read_done !== 1'b1) begin miscompares++; $display("FAIL rst_read_done: got %b want 1", bus.read_done); end
        vectors++; if (bus.udp_tx_data !== 8'd0 || bus.udp_tx_len !== 16'd0 || bus.udp_tx_req !== 1'b0) begin
            miscompares++; $display("FAIL rst_tx_outputs: got data %02h len %0d req %b want 0", bus.udp_tx_data, bus.udp_tx_len, bus.udp_tx_req); end
        vectors++; if (bus.pkt_seq !== 16'd0) begin miscompares++; $display("FAIL rst_pkt_seq: got %0d want 0", bus.pkt_seq); end
        @(posedge clk); #1;
        rst = 1'b0;
        fifo_flush = 1'b1;
        @(posedge clk); #1;
        fifo_flush = 1'b0;
        base = pop_cnt;
        preload(32, 0, 1'b1);
        do_arm();
        vectors++; if (bus.pkt_seq !== 16'd0) begin miscompares++; $display("FAIL rearm_pkt_seq: got %0d want 0", bus.pkt_seq); end
        engine_packet(0, H + 1024, 0, got, len, hb, ps);
        vectors++; if (len != 1024 + H) begin miscompares++; $display("FAIL rearm_len: got %0d want %0d", len, 1024 + H); end
`ifdef LA_UPLOAD_HEADER_EN
        vectors++; if ({rx[0], rx[1], rx[2], rx[3]} !== 32'h000020A5) begin
            miscompares++; $display("FAIL rearm_hdr: got %02h %02h %02h %02h want 00 00 20 a5", rx[0], rx[1], rx[2], rx[3]); end
`endif
        errs = 0;
        for (int i = 0; i < 1024; i++) if (rx[H+i] !== exp_byte(i/32, i%32, 1'b1)) errs++;
        vectors++; if (errs != 0) begin miscompares++; $display("FAIL rearm_payload: got %0d bad bytes want 0", errs); end
        wait_read_done(4, seen);
        vectors++; if (!seen || bus.pkt_seq !== 16'd1) begin
            miscompares++; $display("FAIL rearm_end: got read_done %b pkt_seq %0d want 1 and 1", seen, bus.pkt_seq); end
        vectors++; if (pop_cnt - base != 32) begin miscompares++; $display("FAIL rearm_pops: got %0d want 32", pop_cnt - base); end
    endtask

    initial begin
        bus.arm             = 1'b0;
        bus.capture_done    = 1'b0;
        bus.udp_tx_ack      = 1'b0;
        bus.udp_tx_data_req = 1'b0;
        bus.udp_tx_done     = 1'b0;
        test_reset();
        test_two_full();
        test_short_final();
        test_stream();
        test_ack_delay();
        test_empty_done();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion within 3 ms want bench end");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/la_eth_uploader.md
Name: la_eth_uploader

Overview:
- Downstream stage of the logic-analyser capture path.
- Drains the 256-bit sample-word FIFO filled by the capture block, splits it into UDP packets, and serialises each word to bytes for the UDP transmit engine.
- Drives the read-done level back to the capture block so it can re-arm.

Parameters:
- WORD_WIDTH, 256, FIFO word width in bits; must be a multiple of 8 (32 byte lanes at default).
- CNT_WIDTH, 10, width of the FIFO read-side word count.
- PKT_WORDS, 32, maximum FIFO words per packet (1024 payload bytes at default).
- LEN_WIDTH, 16, width of the packet length field.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  single-cycle pulse: a new capture is being started.
- capture_done  in  1  level from the capture block: the final partial word has been written.
- fifo_dout  in  WORD_WIDTH  show-ahead FIFO head word.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_cnt  in  CNT_WIDTH  words currently held in the FIFO.
- fifo_rd_en  out  1  pops the head word.
- udp_tx_req  out  1  packet request, held until acknowledged.
- udp_tx_len  out  LEN_WIDTH  payload bytes of the requested packet.
- udp_tx_ack  in  1  one-cycle grant of the request.
- udp_tx_data_req  in  1  engine asks for the next payload byte.
- udp_tx_data  out  8  payload byte.
- udp_tx_done  in  1  one-cycle pulse: packet fully sent.
- read_done  out  1  level: upload finished, capture may re-arm.
- pkt_seq  out  16  count of packets sent since the last arm.

Behaviour:
- Reset values:
  - read_done = 1.
  - All other outputs = 0.
  - FSM in IDLE.
- FSM states: IDLE, WAIT, REQ, SEND, GAP.
- IDLE:
  - arm → clear read_done and pkt_seq, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If fifo_rd_cnt >= PKT_WORDS: n = PKT_WORDS, go to REQ.
  - Else if capture_done and fifo_rd_cnt > 0: n = fifo_rd_cnt, a short final packet, go to REQ.
  - Else if capture_done and fifo_empty: set read_done, go to IDLE.
- REQ:
  - Register udp_tx_len = n*32 and assert udp_tx_req.
  - Load word_buf <= fifo_dout and pulse fifo_rd_en for one cycle.
  - Set byte_idx = 0 and words_left = n-1.
  - udp_tx_ack → drop udp_tx_req, go to SEND.
  - The request stays asserted with the length stable until ack.
- SEND, on each udp_tx_data_req cycle:
  - udp_tx_data <= word_buf[byte_idx*8 +: 8], valid the cycle after the request (1-cycle latency).
  - Lane 0 (bits 7:0) is sent first.
  - byte_idx increments, wrapping after 31.
- SEND, when byte_idx == 31 is consumed and words_left > 0:
  - In the same cycle: word_buf <= fifo_dout, fifo_rd_en = 1, words_left decrements.
  - No bubble: a back-to-back data_req on the next cycle receives byte 0 of the new word.
- SEND, when byte_idx == 31 is consumed and words_left == 0: no pop; go to GAP.
- GAP: wait for udp_tx_done, then pkt_seq++ (wraps at 16 bits) and return to WAIT.
- udp_tx_done arriving earlier, in SEND, is latched and honoured on entry to GAP.
- Extra udp_tx_data_req after the last byte:
  - udp_tx_data repeats the last byte.
  - No pop and no counter change.
- fifo_rd_en never asserts while fifo_empty. A guaranteed pop finding fifo_empty is a protocol error; the block holds its state until data appears.
- arm outside IDLE is ignored.
- rst mid-packet: immediate return to reset values. The FIFO is not flushed by this block.
- fifo_rd_en is always a single-cycle pulse per word. There are exactly n pops per packet.

Optional Feature:
- Macro: LA_UPLOAD_HEADER_EN.
- Defined:
  - Each packet is prefixed by a 4-byte header: pkt_seq[15:8], pkt_seq[7:0], words[7:0], 8'hA5.
  - udp_tx_len = n*32 + 4.
  - Payload bytes follow the header with no gap.
  - A header state HDR is inserted between REQ-ack and SEND; it uses the same data_req/1-cycle latency rule.
- Undefined: no header, and udp_tx_len = n*32 exactly.

Test Plan:
- Reset, then arm with 64 words preloaded and capture_done = 1:
  - Two packets, each with udp_tx_len = 1024.
  - Exactly 64 fifo_rd_en pulses.
  - pkt_seq = 2.
  - read_done rises after the second udp_tx_done.
- 40 words preloaded with capture_done set:
  - First packet 1024 bytes, second packet 256 bytes (8 words).
  - read_done = 1 afterwards.
- Continuous udp_tx_data_req with word k lane j = {k[4:0], j[2:0]}:
  - Byte stream order is lane 0..31 of word 0, then word 1, with no gaps or duplicates.
  - Word-boundary pop occurs on the byte-31 cycle.
- udp_tx_ack delayed 10 cycles:
  - udp_tx_req stays high and udp_tx_len stays stable.
  - No second pop before SEND.
- capture_done with an empty FIFO right after arm:
  - No udp_tx_req.
  - read_done returns to 1 within 2 cycles.
- rst asserted mid-SEND:
  - All outputs return to reset values asynchronously.
  - A subsequent arm restarts cleanly with pkt_seq = 0.
  - With LA_UPLOAD_HEADER_EN defined, the first 4 bytes are 00 00 20 A5 and udp_tx_len = 1028.
